multi_edge_detector: RTL

- Parametrised, multi-channel successor of the single-channel encoder edge detector.
- Per channel, in order:
  - synchronises an asynchronous input;
  - applies a stability (debounce) filter;
  - detects rising, falling or both edges, selected per channel;
  - emits a one-cycle pulse with direction, a sticky flag and a saturating event count.
- Sits between raw encoder/button pins and the counter/FSM logic, replacing ad-hoc per-signal detectors.

---
 rtl/multi_edge_detector.sv | 118 +++++++++++
 1 files changed

// File: rtl/multi_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : multi_edge_detector
// Brief    : N-channel synchronise / debounce / edge-detect block. Each
//            channel gives a one-cycle edge pulse with direction, a sticky
//            flag and a saturating event count.
// Revision : 1.0 - initial release
// ============================================================================
module multi_edge_detector #(
  parameter int   N           = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEBOUNCE    = 4,
  parameter int   CNT_W       = 8,
  parameter logic INIT_LEVEL  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,         // asynchronous, active low
  input  logic [N-1:0]       sig_in,
  input  logic [2*N-1:0]     mode,
  input  logic [N-1:0]       clr,
  output logic [N-1:0]       edge_pulse,
  output logic [N-1:0]       edge_dir,
  output logic [N-1:0]       level,
  output logic [N-1:0]       edge_flag,
  output logic [N*CNT_W-1:0] edge_cnt
);

  localparam int               DB_W       = $clog2(DEBOUNCE) + 1;
  localparam logic [DB_W-1:0]  c_db_last  = DB_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
      logic                   level_q, level_d;
      logic                   pulse_q, pulse_d;
      logic                   dir_q, dir_d;
      logic                   flag_q, flag_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   w_s;
      logic                   w_accept;
      logic                   w_qualify;

      assign w_s = sync_q[SYNC_STAGES-1];

      // Next-state: sync shift, debounce, edge qualification, flag/count.
      always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in[gi]};
        db_cnt_d  = db_cnt_q;
        level_d   = level_q;
        w_accept  = 1'b0;

        // A new level must be seen on DEBOUNCE consecutive cycles; any
        // return to the current level restarts the count.
        if (w_s == level_q) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == c_db_last) begin
          level_d  = w_s;
          db_cnt_d = '0;
          w_accept = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end

        // Mode only matters in the accept cycle; level tracks regardless.
        w_qualify = w_accept & ((w_s & mode[2*gi]) | (~w_s & mode[2*gi+1]));

        pulse_d = w_qualify;
        dir_d   = w_qualify ? w_s : dir_q;

        // Clear first, so a simultaneous qualify lands on a fresh count.
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (clr[gi]) begin
          flag_d = 1'b0;
          cnt_d  = '0;
        end
        if (w_qualify) begin
          flag_d = 1'b1;
          if (cnt_d != c_cnt_max) begin
            cnt_d = cnt_d + 1'b1;
          end
        end
      end

      // Channel state register with asynchronous active-low clear.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_q   <= {SYNC_STAGES{INIT_LEVEL}};
          db_cnt_q <= '0;
          level_q  <= INIT_LEVEL;
          pulse_q  <= 1'b0;
          dir_q    <= 1'b0;
          flag_q   <= 1'b0;
          cnt_q    <= '0;
        end else begin
          sync_q   <= sync_d;
          db_cnt_q <= db_cnt_d;
          level_q  <= level_d;
          pulse_q  <= pulse_d;
          dir_q    <= dir_d;
          flag_q   <= flag_d;
          cnt_q    <= cnt_d;
        end
      end

      assign edge_pulse[gi]               = pulse_q;
      assign edge_dir[gi]                 = dir_q;
      assign level[gi]                    = level_q;
      assign edge_flag[gi]                = flag_q;
      assign edge_cnt[gi*CNT_W +: CNT_W]  = cnt_q;
    end
  endgenerate

endmodule
`default_nettype wire
